// File: rtl/mem_load_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: the FSM state encoding and
// the default address and data widths that DP and the memory macro also use.
package mem_load_arbiter_pkg;

    localparam int AW_DEFAULT = 5;
    localparam int DW_DEFAULT = 8;

    typedef enum logic [2:0] {
        ST_RUN    = 3'd0,
        ST_DRAIN  = 3'd1,
        ST_LOAD   = 3'd2,
        ST_WRITE  = 3'd3,
        ST_RESUME = 3'd4
    } state_t;

endpackage

// File: rtl/mem_load_arbiter_sync_edge.sv
// Synchroniser chain for a raw front-panel input, plus a registered
// single-cycle pulse on its synchronised rising edge.
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic pulse
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;
    logic              prev_q;
    logic              prev_d;
    logic              pulse_q;
    logic              pulse_d;

    // Shift chain: stage 0 takes the raw input, each later stage the one before.
    assign sync_d[0] = din;
    for (genvar gi = 1; gi < STAGES; gi++) begin : g_chain
        assign sync_d[gi] = sync_q[gi-1];
    end

    // Edge detector: remember the last synchronised level, pulse on 0->1.
    always_comb begin
        prev_d  = sync_q[STAGES-1];
        pulse_d = sync_q[STAGES-1] & ~prev_q;
    end

    // State registers, all cleared by the synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q  <= '0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            prev_q  <= prev_d;
            pulse_q <= pulse_d;
        end
    end

    assign level = sync_q[STAGES-1];
    assign pulse = pulse_q;

endmodule

// File: rtl/mem_load_arbiter.sv
// Shares the single program/data memory port between the CU/DP (run mode)
// and the front-panel loader (load mode), holding the CU while loading and
// pulsing a processor reset when run mode resumes.
module mem_load_arbiter
    import mem_load_arbiter_pkg::*;
#(
    parameter int AW          = AW_DEFAULT,
    parameter int DW          = DW_DEFAULT,
    parameter int RST_CYCLES  = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          mode_load,
    input  logic          enter,
    input  logic [DW-1:0] sw_data,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_hold,
    output logic          cpu_rst,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [AW-1:0] load_addr,
    output logic [DW-1:0] disp_data
);

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] load_addr_q, load_addr_d;
    logic [DW-1:0] disp_q, disp_d;
    logic          rvalid_q, rvalid_d;
    logic          mode_sync;
    logic          ent_pulse;
    logic          mode_pulse_unused;
    logic          enter_level_unused;

    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_enter (
        .clock (clock),
        .reset (reset),
        .din   (enter),
        .level (enter_level_unused),
        .pulse (ent_pulse)
    );

    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_mode (
        .clock (clock),
        .reset (reset),
        .din   (mode_load),
        .level (mode_sync),
        .pulse (mode_pulse_unused)
    );

    // Next-state and port steering; the loader owns the port outside RUN.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        load_addr_d = load_addr_q;
        disp_d      = disp_q;
        rvalid_d    = 1'b0;
        cpu_gnt     = 1'b0;
        cpu_hold    = 1'b1;
        cpu_rst     = 1'b0;
        mem_addr    = load_addr_q;
        mem_we      = 1'b0;
        mem_wdata   = sw_data;
        case (state_q)
            ST_RUN: begin
                cpu_hold  = 1'b0;
                cpu_gnt   = cpu_req;
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
                mem_we    = cpu_req & cpu_we;
                rvalid_d  = cpu_req & ~cpu_we;
                if (mode_sync) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // One cycle for a read granted in the last RUN cycle to return.
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                disp_d = mem_rdata;
                if (ent_pulse) begin
                    state_d = ST_WRITE;
                end else if (!mode_sync) begin
                    state_d = ST_RESUME;
                    cnt_d   = '0;
                end
            end
            ST_WRITE: begin
                mem_we      = 1'b1;
                load_addr_d = load_addr_q + 1'b1;
                state_d     = ST_LOAD;
            end
            ST_RESUME: begin
                cpu_rst = 1'b1;
                if (cnt_q == 4'(RST_CYCLES - 1)) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
        // Reset aborts any access in the same cycle, including a loader write.
        if (reset) begin
            cpu_gnt = 1'b0;
            mem_we  = 1'b0;
        end
    end

    // State, counter, loader address, display byte and read-valid registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_RUN;
            cnt_q       <= '0;
            load_addr_q <= '0;
            disp_q      <= '0;
            rvalid_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            load_addr_q <= load_addr_d;
            disp_q      <= disp_d;
            rvalid_q    <= rvalid_d;
        end
    end

    assign cpu_rvalid = rvalid_q;
    assign cpu_rdata  = mem_rdata;
    assign load_addr  = load_addr_q;
    assign disp_data  = disp_q;

endmodule

// File: tb/tb_mem_load_arbiter.sv
// Bench for mem_load_arbiter: a synchronous-read memory, a shadow copy of the
// expected memory contents and loader address, a per-cycle monitor, and
// randomised CU traffic interleaved with load sessions.
module tb_mem_load_arbiter;

    localparam int AW   = 5;
    localparam int DW   = 8;
    localparam int RSTC = 2;
    localparam int SS   = 2;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          mode_load = 1'b0;
    logic          enter = 1'b0;
    logic [DW-1:0] sw_data = '0;
    logic          cpu_req = 1'b0;
    logic          cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          cpu_gnt, cpu_rvalid, cpu_hold, cpu_rst, mem_we;
    logic [DW-1:0] cpu_rdata, mem_wdata, disp_data;
    logic [DW-1:0] mem_rdata = '0;
    logic [AW-1:0] mem_addr, load_addr;

    logic [DW-1:0] mem    [0:31];
    logic [DW-1:0] shadow [0:31];
    logic [AW-1:0] model_addr = '0;

    int tests = 0;
    int fails = 0;

    mem_load_arbiter #(.AW(AW), .DW(DW), .RST_CYCLES(RSTC), .SYNC_STAGES(SS)) dut (
        .clock(clock), .reset(reset), .mode_load(mode_load), .enter(enter),
        .sw_data(sw_data), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
        .cpu_rdata(cpu_rdata), .cpu_hold(cpu_hold), .cpu_rst(cpu_rst),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .load_addr(load_addr), .disp_data(disp_data)
    );

    always #5 clock = ~clock;

    // Memory macro: synchronous read (old data), synchronous write.
    always @(posedge clock) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle monitor: arbitration rules, read returns, loader writes, reset pulse.
    logic          mon_on = 1'b0;
    logic          exp_v = 1'b0;
    logic [DW-1:0] exp_d = '0;
    logic          prev_ldwe = 1'b0;
    int            rst_len = 0;

    always @(negedge clock) begin
        if (reset || !mon_on) begin
            exp_v = 1'b0; prev_ldwe = 1'b0; rst_len = 0;
        end else begin
            chk("gnt_rule", cpu_gnt, cpu_req & ~cpu_hold);
            if (cpu_gnt) begin
                chk("run_addr", mem_addr, cpu_addr);
                chk("run_we", mem_we, cpu_we);
                if (cpu_we) chk("run_wdata", mem_wdata, cpu_wdata);
            end
            if (!cpu_hold && !cpu_req) chk("idle_we", mem_we, 0);
            chk("rvalid", cpu_rvalid, exp_v);
            if (exp_v) chk("rdata", cpu_rdata, exp_d);
            if (cpu_gnt && cpu_we) shadow[cpu_addr] = cpu_wdata;
            exp_v = cpu_gnt & ~cpu_we;
            exp_d = shadow[cpu_addr];
            if (cpu_hold && mem_we) begin
                chk("ld_addr", mem_addr, model_addr);
                chk("ld_wdata", mem_wdata, sw_data);
                chk("ld_we_single", prev_ldwe, 0);
            end
            prev_ldwe = cpu_hold & mem_we;
            if (cpu_rst) begin
                chk("rst_hold", cpu_hold, 1);
                rst_len++;
            end else if (rst_len != 0) begin
                chk("rst_len", rst_len, RSTC);
                chk("hold_release", cpu_hold, 0);
                rst_len = 0;
            end
        end
    end

    // All tasks start and end 1 time unit after a rising edge.
    task automatic cu_random(input int n);
        repeat (n) begin
            cpu_req   = 1'($urandom_range(0, 1));
            cpu_we    = 1'($urandom_range(0, 1));
            cpu_addr  = AW'($urandom);
            cpu_wdata = DW'($urandom);
            @(posedge clock); #1;
        end
        cpu_req = 1'b0; cpu_we = 1'b0;
    endtask

    task automatic enter_load();
        int n = 0;
        mode_load = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = AW'($urandom);
        while (!cpu_hold && n < 20) begin
            @(posedge clock); #1; n++;
        end
        chk("enter_hold", cpu_hold, 1);
        cpu_req = 1'b0;
        repeat (4) @(posedge clock);
        #1;
    endtask

    task automatic exit_load();
        int n = 0;
        mode_load = 1'b0;
        while (cpu_hold && n < 40) begin
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = AW'($urandom);
            @(posedge clock); #1; n++;
        end
        chk("exit_run", cpu_hold, 0);
        cpu_req = 1'b1; cpu_addr = AW'($urandom);
        #1 chk("run_gnt", cpu_gnt, 1);
        @(posedge clock); #1;
        cpu_req = 1'b0;
    endtask

    task automatic press(input logic [DW-1:0] d, input int hold);
        logic [AW-1:0] a;
        sw_data = d;
        enter = 1'b1;
        repeat (hold) @(posedge clock);
        #1 enter = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        a = model_addr;
        shadow[a] = d;
        model_addr = model_addr + 1'b1;
        chk("press_mem", mem[a], d);
        chk("press_addr", load_addr, model_addr);
        chk("press_disp", disp_data, shadow[model_addr]);
        chk("press_nognt", cpu_gnt, 0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            mem[i] = DW'($urandom);
            shadow[i] = mem[i];
        end
        mem[5] = 8'h3A; shadow[5] = 8'h3A;

        // Reset with an active CU write request that must not leak through.
        reset = 1'b1; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 5'd5; cpu_wdata = 8'hFF;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_hold", cpu_hold, 0);
        chk("rst_rst", cpu_rst, 0);
        chk("rst_gnt", cpu_gnt, 0);
        chk("rst_rvalid", cpu_rvalid, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_laddr", load_addr, 0);
        chk("rst_disp", disp_data, 0);
        @(posedge clock); #1;
        reset = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; mon_on = 1'b1;

        // Literal CU read of mem[5].
        @(posedge clock); #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'd5;
        @(negedge clock) chk("lit_gnt", cpu_gnt, 1);
        @(posedge clock); #1;
        cpu_req = 1'b0;
        @(negedge clock);
        chk("lit_rvalid", cpu_rvalid, 1);
        chk("lit_rdata", cpu_rdata, 8'h3A);
        @(posedge clock); #1;

        cu_random(200);

        // First load session with literal data, then a 20-cycle held enter.
        enter_load();
        press(8'h05, 1);
        press(8'hA7, 3);
        press(8'hE0, 2);
        chk("lit_laddr3", load_addr, 3);
        chk("lit_mem0", mem[0], 8'h05);
        chk("lit_mem1", mem[1], 8'hA7);
        chk("lit_mem2", mem[2], 8'hE0);
        press(DW'($urandom), 20);
        chk("lit_laddr4", load_addr, 4);

        // Fill up to the last word, then wrap.
        while (model_addr != 5'd31) press(DW'($urandom), $urandom_range(1, 20));
        press(8'h11, 2);
        chk("lit_mem31", mem[31], 8'h11);
        chk("lit_wrap", load_addr, 0);
        exit_load();
        cu_random(50);

        // Random load sessions interleaved with CU traffic.
        repeat (3) begin
            enter_load();
            repeat ($urandom_range(1, 5)) press(DW'($urandom), $urandom_range(1, 20));
            exit_load();
            cu_random(50);
        end

        // Enter pulse coincident with mode_load falling: write wins, then resume.
        enter_load();
        begin
            int n = 0;
            logic [AW-1:0] a;
            sw_data = 8'h6D;
            enter = 1'b1;
            @(posedge clock); #1 mode_load = 1'b0;
            @(posedge clock); #1 enter = 1'b0;
            while (cpu_hold && n < 40) begin
                @(posedge clock); #1; n++;
            end
            chk("coinc_run", cpu_hold, 0);
            a = model_addr;
            shadow[a] = 8'h6D;
            model_addr = model_addr + 1'b1;
            chk("coinc_mem", mem[a], 8'h6D);
            chk("coinc_addr", load_addr, model_addr);
        end
        cu_random(30);

        // Reset asserted during a loader WRITE aborts it.
        enter_load();
        begin
            int n = 0;
            sw_data = 8'h5C;
            enter = 1'b1;
            while (!(mem_we && cpu_hold) && n < 20) begin
                @(posedge clock); #1; n++;
            end
            chk("wr_seen", mem_we & cpu_hold, 1);
            reset = 1'b1; mode_load = 1'b0; enter = 1'b0;
            #1 chk("rstwr_we", mem_we, 0);
            @(posedge clock); #1;
            reset = 1'b0;
            chk("rstwr_hold", cpu_hold, 0);
            chk("rstwr_laddr", load_addr, 0);
            chk("rstwr_rst", cpu_rst, 0);
            chk("rstwr_mem", mem[model_addr], shadow[model_addr]);
            model_addr = '0;
        end
        cu_random(50);
        repeat (3) @(posedge clock);
        #1;

        for (int i = 0; i < 32; i++) chk($sformatf("final_mem%0d", i), mem[i], shadow[i]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Hard time limit so the run always terminates.
    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule
